// File: rtl/sr_pq_param_pkg.sv
// pq_pkg: shared ordering constants, cell op codes and the priority compare helper.
package pq_pkg;
  localparam bit MIN_FIRST = 1'b0;
  localparam bit MAX_FIRST = 1'b1;
  localparam int DEF_KW = 8;
  localparam int DEF_VW = 8;
  localparam int DEF_DEPTH = 8;
  localparam int MAX_KW = 64;
  typedef enum logic [1:0] {OP_NOP, OP_ENQ, OP_DEQ, OP_REP} op_e;
  // keys are unsigned, so zero-extending to MAX_KW preserves their order
  function automatic logic better(input logic [MAX_KW-1:0] a, input logic [MAX_KW-1:0] b, input logic max_first);
    return max_first ? (a > b) : (a < b);
  endfunction
endpackage

// File: rtl/sr_pq_param_if.sv
// sr_pq_param_if: enqueue/dequeue request and head/status bundle of the priority queue.
interface sr_pq_param_if import pq_pkg::*; #(parameter int KW = DEF_KW, parameter int VW = DEF_VW, parameter int CW = 4);
  logic enq;
  logic deq;
  logic clr_err;
  logic [KW-1:0] kvi_key;
  logic [VW-1:0] kvi_val;
  logic [KW-1:0] kvo_key;
  logic [VW-1:0] kvo_val;
  logic full;
  logic empty;
  logic busy;
  logic [CW-1:0] count;
  logic ovf;
  logic udf;
  modport master(output enq, deq, clr_err, kvi_key, kvi_val,
                 input kvo_key, kvo_val, full, empty, busy, count, ovf, udf);
  modport slave(input enq, deq, clr_err, kvi_key, kvi_val,
                output kvo_key, kvo_val, full, empty, busy, count, ovf, udf);
endinterface

// File: rtl/sr_pq_param_cell.sv
// sr_pq_cell: one stage of the sorted shift register; picks own, left, right or new item.
module sr_pq_cell import pq_pkg::*; #(
  parameter int KW = DEF_KW,
  parameter int VW = DEF_VW,
  parameter bit MAX_FIRST = 1'b0,
  parameter bit HEAD = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  op_e op,
  input  logic f_l,
  input  logic f_r,
  input  logic l_valid,
  input  logic [KW-1:0] l_key,
  input  logic [VW-1:0] l_val,
  input  logic r_valid,
  input  logic [KW-1:0] r_key,
  input  logic [VW-1:0] r_val,
  input  logic [KW-1:0] n_key,
  input  logic [VW-1:0] n_val,
  output logic f,
  output logic valid,
  output logic [KW-1:0] key,
  output logic [VW-1:0] val
);
  logic g;
  logic [1:0] sel;
  assign f = !valid || better(MAX_KW'(n_key), MAX_KW'(key), MAX_FIRST);
  // on replace the head leaves, so position i's left flag is this cell's own flag
  assign g = !HEAD && f;
  // sel: 0 keep, 1 take left, 2 take right, 3 load new item
  assign sel = op == OP_ENQ ? (f ? (f_l ? 2'd1 : 2'd3) : 2'd0)
             : op == OP_DEQ ? 2'd2
             : op == OP_REP ? (f_r ? (g ? 2'd0 : 2'd3) : 2'd2)
             : 2'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      key <= '0;
      val <= '0;
    end else begin
      valid <= sel == 2'd0 ? valid : sel == 2'd1 ? l_valid : sel == 2'd2 ? r_valid : 1'b1;
      key <= sel == 2'd0 ? key : sel == 2'd1 ? l_key : sel == 2'd2 ? r_key : n_key;
      val <= sel == 2'd0 ? val : sel == 2'd1 ? l_val : sel == 2'd2 ? r_val : n_val;
    end
  end
endmodule

// File: rtl/sr_pq_param.sv
// sr_pq_param: shift-register priority queue with single-cycle enqueue, dequeue and replace.
module sr_pq_param import pq_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int KW = DEF_KW,
  parameter int VW = DEF_VW,
  parameter bit MAX_FIRST = 1'b0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic rst_n,
  sr_pq_param_if.slave pq
);
  // index 0 and DEPTH+1 are constant empty neighbours of the end cells
  logic [DEPTH+1:0] vx;
  logic [DEPTH+1:0] fx;
  logic [KW-1:0] kx [DEPTH+2];
  logic [VW-1:0] dx [DEPTH+2];
  logic [CW-1:0] cnt;
  logic ovf_q;
  logic udf_q;
  logic full;
  logic empty;
  op_e op;
  assign vx[0] = 1'b0;
  assign vx[DEPTH+1] = 1'b0;
  assign fx[0] = 1'b0;
  assign fx[DEPTH+1] = 1'b1;
  assign kx[0] = '0;
  assign kx[DEPTH+1] = '0;
  assign dx[0] = '0;
  assign dx[DEPTH+1] = '0;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign op = (pq.enq && pq.deq) ? (empty ? OP_ENQ : OP_REP)
            : pq.enq ? (full ? OP_NOP : OP_ENQ)
            : pq.deq ? (empty ? OP_NOP : OP_DEQ)
            : OP_NOP;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    sr_pq_cell #(.KW(KW), .VW(VW), .MAX_FIRST(MAX_FIRST), .HEAD(i == 0)) u_cell (
      .clk(clk), .rst_n(rst_n), .op(op),
      .f_l(fx[i]), .f_r(fx[i+2]),
      .l_valid(vx[i]), .l_key(kx[i]), .l_val(dx[i]),
      .r_valid(vx[i+2]), .r_key(kx[i+2]), .r_val(dx[i+2]),
      .n_key(pq.kvi_key), .n_val(pq.kvi_val),
      .f(fx[i+1]), .valid(vx[i+1]), .key(kx[i+1]), .val(dx[i+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt <= op == OP_ENQ ? cnt + CW'(1) : op == OP_DEQ ? cnt - CW'(1) : cnt;
      ovf_q <= (pq.enq && !pq.deq && full) || (ovf_q && !pq.clr_err);
      udf_q <= (pq.deq && empty) || (udf_q && !pq.clr_err);
    end
  end
  assign pq.kvo_key = kx[1];
  assign pq.kvo_val = dx[1];
  assign pq.full = full;
  assign pq.empty = empty;
  assign pq.busy = 1'b0;
  assign pq.count = cnt;
  assign pq.ovf = ovf_q;
  assign pq.udf = udf_q;
endmodule

// File: tb/tb_sr_pq_param.sv
// tb_sr_pq_param: directed checks of ordering, FIFO ties, replace, error flags and async reset.
module tb_sr_pq_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  sr_pq_param_if #(.KW(8), .VW(8), .CW(4)) pa ();
  sr_pq_param_if #(.KW(8), .VW(8), .CW(4)) pm ();
  sr_pq_param #(.DEPTH(8), .KW(8), .VW(8), .MAX_FIRST(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .pq(pa));
  sr_pq_param #(.DEPTH(8), .KW(8), .VW(8), .MAX_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .pq(pm));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic op(input logic e, input logic [7:0] k, input logic [7:0] v, input logic d, input logic c);
    @(negedge clk);
    pa.enq = e; pa.kvi_key = k; pa.kvi_val = v; pa.deq = d; pa.clr_err = c;
    @(posedge clk);
    #1;
    pa.enq = 1'b0; pa.deq = 1'b0; pa.clr_err = 1'b0;
  endtask
  task automatic mop(input logic e, input logic [7:0] k, input logic d);
    @(negedge clk);
    pm.enq = e; pm.kvi_key = k; pm.kvi_val = k; pm.deq = d;
    @(posedge clk);
    #1;
    pm.enq = 1'b0; pm.deq = 1'b0;
  endtask
  initial begin
    logic [7:0] k1 [5];
    logic [7:0] v1 [5];
    k1 = '{8'd2, 8'd2, 8'd5, 8'd7, 8'd9};
    v1 = '{8'h12, 8'h07, 8'h15, 8'h17, 8'h19};
    pa.enq = 0; pa.deq = 0; pa.clr_err = 0; pa.kvi_key = 0; pa.kvi_val = 0;
    pm.enq = 0; pm.deq = 0; pm.clr_err = 0; pm.kvi_key = 0; pm.kvi_val = 0;
    #12;
    chk("rst_count", pa.count, 0);
    chk("rst_empty", pa.empty, 1);
    chk("rst_full", pa.full, 0);
    chk("rst_busy", pa.busy, 0);
    chk("rst_kvo", {pa.kvo_key, pa.kvo_val}, 0);
    chk("rst_ovf", pa.ovf, 0);
    chk("rst_udf", pa.udf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 5, 8'h15, 0, 0);
    op(1, 2, 8'h12, 0, 0);
    op(1, 9, 8'h19, 0, 0);
    op(1, 2, 8'h07, 0, 0);
    op(1, 7, 8'h17, 0, 0);
    chk("t1_count", pa.count, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_key%0d", i), pa.kvo_key, k1[i]);
      chk($sformatf("t1_val%0d", i), pa.kvo_val, v1[i]);
      op(0, 0, 0, 1, 0);
    end
    chk("t1_empty", pa.empty, 1);
    chk("t1_kvo0", {pa.kvo_key, pa.kvo_val}, 0);
    for (int i = 0; i < 8; i++) op(1, 8'(10 + i), 8'(8'hA0 + i), 0, 0);
    chk("t2_full", pa.full, 1);
    chk("t2_count", pa.count, 8);
    op(1, 3, 8'h33, 0, 0);
    chk("t2_ovf", pa.ovf, 1);
    chk("t2_full2", pa.full, 1);
    chk("t2_count2", pa.count, 8);
    chk("t2_head", {pa.kvo_key, pa.kvo_val}, 16'h0AA0);
    op(0, 0, 0, 0, 1);
    chk("t2_clr", pa.ovf, 0);
    op(1, 20, 8'h44, 1, 0);
    chk("rep20_count", pa.count, 8);
    chk("rep20_ovf", pa.ovf, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rep20_key%0d", i), pa.kvo_key, i == 7 ? 20 : 11 + i);
      chk($sformatf("rep20_val%0d", i), pa.kvo_val, i == 7 ? 8'h44 : 8'hA1 + i);
      op(0, 0, 0, 1, 0);
    end
    chk("rep20_empty", pa.empty, 1);
    for (int i = 0; i < 8; i++) op(1, 8'(10 + i), 8'(8'hA0 + i), 0, 0);
    op(1, 3, 8'h33, 1, 0);
    chk("rep3_head", {pa.kvo_key, pa.kvo_val}, 16'h0333);
    chk("rep3_count", pa.count, 8);
    chk("rep3_ovf", pa.ovf, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rep3_key%0d", i), pa.kvo_key, i == 0 ? 3 : 10 + i);
      op(0, 0, 0, 1, 0);
    end
    op(0, 0, 0, 1, 0);
    chk("udf_set", pa.udf, 1);
    chk("udf_count", pa.count, 0);
    op(0, 0, 0, 0, 1);
    chk("udf_clr", pa.udf, 0);
    op(1, 4, 8'h44, 1, 0);
    chk("edq_count", pa.count, 1);
    chk("edq_key", pa.kvo_key, 4);
    chk("edq_udf", pa.udf, 1);
    chk("edq_empty", pa.empty, 0);
    op(0, 0, 0, 1, 0);
    op(0, 0, 0, 1, 1);
    chk("setwins_udf", pa.udf, 1);
    op(0, 0, 0, 0, 1);
    chk("udf_clr2", pa.udf, 0);
    mop(1, 1, 0);
    mop(1, 8, 0);
    mop(1, 3, 0);
    chk("max_head", pm.kvo_key, 8);
    chk("max_count", pm.count, 3);
    mop(0, 0, 1);
    chk("max_deq1", pm.kvo_key, 3);
    mop(0, 0, 1);
    chk("max_deq2", pm.kvo_key, 1);
    op(1, 6, 8'h66, 0, 0);
    op(1, 1, 8'h11, 0, 0);
    op(1, 4, 8'h44, 0, 0);
    op(1, 9, 8'h99, 0, 0);
    chk("pre_rst_count", pa.count, 4);
    chk("pre_rst_head", pa.kvo_key, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", pa.count, 0);
    chk("arst_kvo", {pa.kvo_key, pa.kvo_val}, 0);
    chk("arst_empty", pa.empty, 1);
    chk("arst_full", pa.full, 0);
    chk("arst_flags", {pa.ovf, pa.udf}, 0);
    chk("arst_m_count", pm.count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
